vec_mem_sequencer: RTL

- Memory-stage front end placed directly upstream of the memory controller.
- Takes one scalar (32-bit) or vector (192-bit, 6 lanes) load/store request from the pipeline MEM stage and serialises it into 32-bit word beats on a scalar memory port.
- Assembles vector load data into one 192-bit result and holds the pipeline with a stall until the access completes.
- Replaces ad-hoc wait-cycle counting with an explicit FSM and handshake.

---
 rtl/vec_mem_pkg.sv | 22 ++
 rtl/vec_lane_buffer.sv | 36 +++
 rtl/vec_mem_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and sizing for the vector memory sequencer.
// Optional feature macro used by the top: VEC_STORE_MASK_EN.
package vec_mem_pkg;

  localparam int SCALAR_W = 32;
  localparam int VECTOR_W = 192;
  localparam int LANES    = VECTOR_W / SCALAR_W;

  // Beat counter width for a given lane count; a single lane still needs one bit.
  function automatic int beat_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int BEAT_W = beat_width(LANES);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

endpackage

// File: rtl/vec_lane_buffer.sv
// Lane-addressed assembly buffer: L words of S bits, one lane written per
// cycle, cleared synchronously at the start of each access, read out flat.
module vec_lane_buffer #(
  parameter int S  = 32,
  parameter int L  = 6,
  parameter int BW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [BW-1:0] lane_i,
  input  logic [S-1:0]  wd_i,
  output logic [L*S-1:0] data_o
);

  logic [S-1:0] lane_q [L];

  // Clear takes priority so a fresh access never sees stale lanes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < L; i++) lane_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < L; i++) lane_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < L; i++) begin
        if (lane_i == BW'(i)) lane_q[i] <= wd_i;
      end
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_flat
    assign data_o[g*S +: S] = lane_q[g];
  end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Memory-stage front end: serialises one scalar or vector request into
// S-bit beats on a scalar memory port and assembles vector load data.
// Optional feature macro: VEC_STORE_MASK_EN (per-lane write mask on vector stores).
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int S = SCALAR_W,
  parameter int V = VECTOR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
`ifdef VEC_STORE_MASK_EN
  input  logic [V/S-1:0] req_mask,
`endif
  output logic         stall,
  output logic         resp_valid,
  output logic [V-1:0] resp_rd,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd
);

  localparam int L  = V / S;
  localparam int BW = beat_width(L);

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] last_q;
  logic          we_q;
  logic [S-1:0]  addr_q;
  logic [V-1:0]  wd_q;
`ifdef VEC_STORE_MASK_EN
  logic          vec_q;
  logic [L-1:0]  mask_q;
`endif

  logic          accept;
  logic          in_xfer;
  logic          lane_en;
  logic [S-1:0]  lane_wd;

  assign accept  = (state_q == IDLE) && req_valid;
  assign in_xfer = (state_q == XFER);

  // Sequencer: latch the request on acceptance, walk the beats, then one DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
`ifdef VEC_STORE_MASK_EN
      vec_q   <= 1'b0;
      mask_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wd_q    <= req_wd;
            beat_q  <= '0;
            last_q  <= req_vec ? BW'(L - 1) : '0;
`ifdef VEC_STORE_MASK_EN
            vec_q   <= req_vec;
            mask_q  <= req_mask;
`endif
            state_q <= XFER;
          end
        end
        XFER: begin
          if (beat_q == last_q) state_q <= DONE;
          else                  beat_q  <= beat_q + BW'(1);
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Select the store word for the current beat and decide whether it is written.
  always_comb begin
    lane_wd = '0;
    for (int i = 0; i < L; i++) begin
      if (beat_q == BW'(i)) lane_wd = wd_q[i*S +: S];
    end
`ifdef VEC_STORE_MASK_EN
    lane_en = vec_q ? mask_q[beat_q] : 1'b1;
`else
    lane_en = 1'b1;
`endif
  end

  // Port drive: memory signals live only in XFER and fall with the state on reset.
  always_comb begin
    stall      = in_xfer || accept;
    resp_valid = (state_q == DONE);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    if (in_xfer) begin
      mem_we   = we_q && lane_en;
      mem_addr = addr_q + S'(beat_q);
      mem_wd   = lane_wd;
    end
  end

  vec_lane_buffer #(
    .S  (S),
    .L  (L),
    .BW (BW)
  ) u_buf (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (accept),
    .we_i   (in_xfer && !we_q),
    .lane_i (beat_q),
    .wd_i   (mem_rd),
    .data_o (resp_rd)
  );

endmodule
